// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard/stall controller: load-use and branch-in-decode stalls, decode forwarding, flush, halt, debug step.
// Latency: stall/flush/forward outputs are combinational in the hazard cycle; halted_o rises the cycle after halt is accepted.
// Backpressure: stalls drop PC/IF-ID enables and inject an ID/EX bubble; debug freeze holds everything. Perf counters need HAZARD_PERF_EN.
module decode_hazard_ctrl #(
    parameter int NB_REG          = 5,
    parameter int NB_CNT          = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int BR_ALU_CYCLES   = 1,
    parameter int BR_LOAD_CYCLES  = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [NB_REG-1:0] id_rs_i,
    input  logic [NB_REG-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_branch_i,
    input  logic              id_halt_i,
    input  logic              branch_taken_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [NB_REG-1:0] ex_dest_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    input  logic [NB_REG-1:0] mem_dest_i,
    input  logic              wb_reg_write_i,
    input  logic [NB_REG-1:0] wb_dest_i,
    input  logic              debug_mode_i,
    input  logic              step_i,
    output logic              pc_write_en_o,
    output logic              if_id_write_en_o,
    output logic              id_ex_bubble_o,
    output logic              if_id_flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic              halted_o,
    output logic [31:0]       stall_count_o,
    output logic [31:0]       flush_count_o
);

    if (LOAD_USE_CYCLES > 2**NB_CNT-1 || BR_ALU_CYCLES > 2**NB_CNT-1 ||
        BR_LOAD_CYCLES > 2**NB_CNT-1) begin : g_cnt_too_narrow
        $error("decode_hazard_ctrl: stall cycle parameter exceeds NB_CNT counter range");
    end

    localparam logic [NB_CNT-1:0] LU_N  = NB_CNT'(LOAD_USE_CYCLES);
    localparam logic [NB_CNT-1:0] BA_N  = NB_CNT'(BR_ALU_CYCLES);
    localparam logic [NB_CNT-1:0] BL_N  = NB_CNT'(BR_LOAD_CYCLES);
    localparam logic [NB_CNT-1:0] ONE_N = NB_CNT'(1);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t              state;
    logic [NB_CNT-1:0]   cnt;
    logic [NB_CNT-1:0]   need;
    logic                ex_hit;
    logic                mem_hit;
    logic                enabled;

    function automatic logic [1:0] fwd_sel(
        input logic [NB_REG-1:0] src,
        input logic              m_wr,
        input logic              m_rd,
        input logic [NB_REG-1:0] m_dst,
        input logic              w_wr,
        input logic [NB_REG-1:0] w_dst
    );
        if (m_wr && !m_rd && m_dst != '0 && m_dst == src)
            return 2'b01;
        else if (w_wr && w_dst != '0 && w_dst == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign ex_hit  = (ex_dest_i != '0) &&
                     ((id_uses_rs_i && ex_dest_i == id_rs_i) || (id_uses_rt_i && ex_dest_i == id_rt_i));
    assign mem_hit = (mem_dest_i != '0) &&
                     ((id_uses_rs_i && mem_dest_i == id_rs_i) || (id_uses_rt_i && mem_dest_i == id_rt_i));

    // Largest stall demanded by any hazard rule that fires this cycle.
    always_comb begin
        need = '0;
        if (ex_mem_read_i && ex_hit && LU_N > need)
            need = LU_N;
        if (id_branch_i && ex_mem_read_i && ex_hit && BL_N > need)
            need = BL_N;
        if (id_branch_i && ex_reg_write_i && !ex_mem_read_i && ex_hit && BA_N > need)
            need = BA_N;
        if (id_branch_i && mem_mem_read_i && mem_hit && ONE_N > need)
            need = ONE_N;
    end

    assign enabled  = !debug_mode_i || step_i;
    assign stall_o  = (state == STALL) || (state == RUN && need != '0);
    assign halted_o = (state == HALT);

    always_comb begin
        pc_write_en_o    = 1'b0;
        if_id_write_en_o = 1'b0;
        id_ex_bubble_o   = 1'b0;
        if_id_flush_o    = 1'b0;
        if (enabled) begin
            if (state == HALT || stall_o) begin
                id_ex_bubble_o = 1'b1;
            end else begin
                pc_write_en_o    = 1'b1;
                if_id_write_en_o = 1'b1;
                if_id_flush_o    = branch_taken_i;
            end
        end
    end

    assign fwd_a_o = fwd_sel(id_rs_i, mem_reg_write_i, mem_mem_read_i, mem_dest_i, wb_reg_write_i, wb_dest_i);
    assign fwd_b_o = fwd_sel(id_rt_i, mem_reg_write_i, mem_mem_read_i, mem_dest_i, wb_reg_write_i, wb_dest_i);

    // Counter holds the stall cycles still owed after the current one.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= RUN;
            cnt   <= '0;
        end else if (enabled) begin
            case (state)
                RUN: begin
                    if (need > ONE_N) begin
                        cnt   <= need - ONE_N;
                        state <= STALL;
                    end else if (need == '0 && id_halt_i) begin
                        state <= HALT;
                    end
                end
                STALL: begin
                    if (cnt == ONE_N) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt - ONE_N;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (enabled && stall_o && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush_o && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
`else
    assign stall_count_o = 32'd0;
    assign flush_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed plus randomized bench for decode_hazard_ctrl against a cycle-count reference model.
module tb_decode_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [4:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
    logic       uses_rs, uses_rt, id_branch, id_halt, taken;
    logic       ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, dbg, step;
    logic       pc_we, ifid_we, bubble, flush, stall, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    int      m_rem;
    bit      m_halted;
    longint  m_sc, m_fc;

    always #5 clk = ~clk;

    decode_hazard_ctrl dut (
        .clock_i(clk), .reset_i(reset_i),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
        .id_branch_i(id_branch), .id_halt_i(id_halt), .branch_taken_i(taken),
        .ex_reg_write_i(ex_rw), .ex_mem_read_i(ex_mr), .ex_dest_i(ex_dest),
        .mem_reg_write_i(mem_rw), .mem_mem_read_i(mem_mr), .mem_dest_i(mem_dest),
        .wb_reg_write_i(wb_rw), .wb_dest_i(wb_dest),
        .debug_mode_i(dbg), .step_i(step),
        .pc_write_en_o(pc_we), .if_id_write_en_o(ifid_we), .id_ex_bubble_o(bubble),
        .if_id_flush_o(flush), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .stall_o(stall), .halted_o(halted),
        .stall_count_o(stall_cnt), .flush_count_o(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] d);
        return d != 0 && ((uses_rs && d == id_rs) || (uses_rt && d == id_rt));
    endfunction

    // Required stall cycles straight from the hazard table (default parameters 1/1/2).
    function automatic int need_cycles();
        int n = 0;
        if (ex_mr && hit(ex_dest)) n = (n > 1) ? n : 1;
        if (id_branch && ex_mr && hit(ex_dest)) n = (n > 2) ? n : 2;
        if (id_branch && ex_rw && !ex_mr && hit(ex_dest)) n = (n > 1) ? n : 1;
        if (id_branch && mem_mr && hit(mem_dest)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (mem_rw && !mem_mr && mem_dest != 0 && mem_dest == src) return 2'b01;
        if (wb_rw && wb_dest != 0 && wb_dest == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        return m_rem > 0 || (!m_halted && need_cycles() > 0);
    endfunction

    task automatic check_model();
        bit en, st;
        logic [3:0] exp_ctl;
        en = !dbg || step;
        st = m_stall();
        if (!en)                 exp_ctl = 4'b0000;
        else if (m_halted || st) exp_ctl = 4'b0010;
        else                     exp_ctl = {3'b110, taken};
        chk("stall", stall, st);
        chk("halted", halted, m_halted);
        chk("ctl{pc,ifid,bub,flush}", {pc_we, ifid_we, bubble, flush}, exp_ctl);
        chk("fwd_a", fwd_a, fwd_model(id_rs));
        chk("fwd_b", fwd_b, fwd_model(id_rt));
`ifdef HAZARD_PERF_EN
        chk("stall_count", stall_cnt, m_sc[31:0]);
        chk("flush_count", flush_cnt, m_fc[31:0]);
`else
        chk("stall_count", stall_cnt, 0);
        chk("flush_count", flush_cnt, 0);
`endif
    endtask

    task automatic probe();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        bit en, st, fl;
        int n;
        en = !dbg || step;
        st = m_stall();
        n  = need_cycles();
        fl = en && !st && !m_halted && taken;
        @(posedge clk);
        if (en && st && m_sc != 64'hFFFF_FFFF) m_sc++;
        if (fl && m_fc != 64'hFFFF_FFFF) m_fc++;
        if (en && !m_halted) begin
            if (m_rem > 0)      m_rem--;
            else if (n > 0)     m_rem = n - 1;
            else if (id_halt)   m_halted = 1;
        end
        #1;
    endtask

    task automatic idle();
        {id_rs, id_rt, ex_dest, mem_dest, wb_dest} = '0;
        {uses_rs, uses_rt, id_branch, id_halt, taken} = '0;
        {ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, dbg, step} = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        #1;
        m_rem = 0; m_halted = 0; m_sc = 0; m_fc = 0;
        check_model();
        #1 reset_i = 1'b1;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        #3;
        do_reset();
        probe();
        chk("reset_pc_we", pc_we, 1);
        adv();

        // lw r3 in EX, add reading r3
        ex_mr = 1; ex_rw = 1; ex_dest = 3; uses_rs = 1; id_rs = 3;
        probe();
        chk("lu_stall", stall, 1); chk("lu_bubble", bubble, 1); chk("lu_pc_we", pc_we, 0);
        adv();
        ex_mr = 0; ex_dest = 0;
        probe();
        chk("lu_release", stall, 0); chk("lu_pc_we_after", pc_we, 1);
        adv();

        // lw r4 in EX, beq reading r4: two stall cycles
        idle(); ex_mr = 1; ex_rw = 1; ex_dest = 4; id_branch = 1; uses_rs = 1; id_rs = 4;
        probe(); chk("bl_stall0", stall, 1); adv();
        probe(); chk("bl_stall1", stall, 1); adv();
        ex_mr = 0; ex_rw = 0; ex_dest = 0;
        probe(); chk("bl_release", stall, 0); adv();

        // add r5 in EX, bne reading rt=5; then r5 forwarded from EX/MEM
        idle(); ex_rw = 1; ex_dest = 5; id_branch = 1; uses_rt = 1; id_rt = 5;
        probe(); chk("ba_stall", stall, 1); adv();
        ex_rw = 0; ex_dest = 0; mem_rw = 1; mem_dest = 5;
        probe(); chk("ba_no_stall", stall, 0); chk("ba_fwd_b", fwd_b, 2'b01); adv();

        // r0 never hazards; EX/MEM wins over MEM/WB
        idle(); ex_mr = 1; ex_dest = 0; uses_rs = 1; id_rs = 0;
        probe(); chk("r0_no_stall", stall, 0); adv();
        idle(); mem_rw = 1; mem_dest = 7; wb_rw = 1; wb_dest = 7; id_rs = 7; uses_rs = 1;
        probe(); chk("fwd_prio", fwd_a, 2'b01); adv();

        // taken branch flush, then halt
        idle(); taken = 1;
        probe(); chk("flush_taken", flush, 1); adv();
        taken = 0; id_halt = 1;
        probe(); chk("halt_pre", halted, 0); adv();
        id_halt = 0;
        probe(); chk("halt_set", halted, 1); adv();
        probe(); chk("halt_hold", halted, 1); chk("halt_pc_we", pc_we, 0); adv();

        // reset in the middle of a branch-load stall
        do_reset();
        ex_mr = 1; ex_dest = 4; id_branch = 1; uses_rs = 1; id_rs = 4;
        probe(); adv();
        idle();
        #1 reset_i = 1'b0;
        #1;
        chk("rst_mid_stall", stall, 0); chk("rst_mid_halted", halted, 0);
        m_rem = 0; m_halted = 0; m_sc = 0; m_fc = 0;
        #1 reset_i = 1'b1;

        // debug stepping through a 2-cycle branch-load stall
        ex_mr = 1; ex_dest = 4; id_branch = 1; uses_rs = 1; id_rs = 4; dbg = 1; step = 0;
        probe(); chk("dbg_frozen_pc", pc_we, 0); chk("dbg_frozen_bub", bubble, 0); adv();
        step = 1; probe(); adv();
        step = 0; probe(); adv();
        step = 1; probe(); adv();
        ex_mr = 0; ex_dest = 0; id_branch = 0;
        probe(); chk("dbg_released", stall, 0);
`ifdef HAZARD_PERF_EN
        chk("dbg_perf", stall_cnt, 2);
`endif
        adv();
        step = 0; dbg = 0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            id_rs    = 5'($urandom_range(0, 3));
            id_rt    = 5'($urandom_range(0, 3));
            ex_dest  = 5'($urandom_range(0, 3));
            mem_dest = 5'($urandom_range(0, 3));
            wb_dest  = 5'($urandom_range(0, 3));
            uses_rs  = 1'($urandom);
            uses_rt  = 1'($urandom);
            id_branch = 1'($urandom);
            taken    = 1'($urandom);
            ex_rw    = 1'($urandom);
            ex_mr    = ($urandom_range(0, 9) < 3);
            mem_rw   = 1'($urandom);
            mem_mr   = ($urandom_range(0, 9) < 3);
            wb_rw    = 1'($urandom);
            id_halt  = ($urandom_range(0, 39) == 0);
            dbg      = ($urandom_range(0, 4) == 0);
            step     = 1'($urandom);
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            probe();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
